store_buffer: RTL and testbench

Posted-store buffer between the EX/MEM pipeline register and the data memory. It queues stores and forwards loads straight to memory. Buffered stores drain to memory on idle cycles or when the queue is full. It drives the memory port with the existing 2-bit size encoding, checks alignment, and stalls a load whose word overlaps a pending store.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/store_fifo.sv | 86 ++++++++
 rtl/store_buffer.sv | 106 ++++++++++
 tb/tb_store_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory size encodings, store entry type and alignment helper
package mem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } sb_entry_t;

  // Words need a 4-byte boundary, halves a 2-byte one; bytes (and "none") always pass.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      MEM_WORD: ok = (addr_lo == 2'b00);
      MEM_HALF: ok = ~addr_lo[0];
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - posted-store queue with per-entry valid and word-address compare
module store_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  sb_entry_t                push_entry,
  input  logic [9:0]               cmp_word,
  output sb_entry_t                head_entry,
  output logic [DEPTH-1:0]         match,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t          entries [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW:0]        cnt;
  logic               do_push;
  logic               do_pop;

  assign full       = (cnt == (PW+1)'(DEPTH));
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign head_entry = entries[head];

  // A push into a full queue is only honoured when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Entry payload needs no reset: valid bits decide whether it is ever looked at.
  always_ff @(posedge Clk) begin
    if (do_push) entries[tail] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
    end
  end

  // Clear before set so a full-queue push/pop on the same slot leaves it valid.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid <= '0;
    end else begin
      if (do_pop)  valid[head] <= 1'b0;
      if (do_push) valid[tail] <= 1'b1;
    end
  end

  // Occupancy moves by at most one; simultaneous push and pop cancel.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Word-granular overlap against every registered valid entry, including one popping now.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (entries[i].addr[11:2] == cmp_word);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store buffer: request decode, priority and load hazard stall
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [1:0]               MemWriteIn,
  input  logic [1:0]               MemReadIn,
  input  logic [31:0]              AddrIn,
  input  logic [31:0]              WriteDataIn,
  output logic [31:0]              Address,
  output logic [31:0]              WriteData,
  output logic [1:0]               MemWrite,
  output logic [1:0]               MemRead,
  output logic                     Stall,
  output logic                     ReqError,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  sb_entry_t        push_entry;
  sb_entry_t        head_entry;
  logic [DEPTH-1:0] match;
  logic             is_store;
  logic             is_load;
  logic             illegal;
  logic             load_ok;
  logic             store_ok;
  logic             hazard;
  logic             push;
  logic             drain;

  assign push_entry = '{addr: AddrIn, data: WriteDataIn, size: MemWriteIn};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk        (Clk),
    .Rst        (Rst),
    .push       (push),
    .pop        (drain),
    .push_entry (push_entry),
    .cmp_word   (AddrIn[11:2]),
    .head_entry (head_entry),
    .match      (match),
    .count      (Count),
    .full       (Full),
    .empty      (Empty)
  );

  // Classify the request: simultaneous read+write or bad alignment drops it entirely.
  always_comb begin
    is_store = (MemWriteIn != MEM_NONE);
    is_load  = (MemReadIn != MEM_NONE);
    illegal  = (is_store && is_load)
            || (is_store && !aligned(MemWriteIn, AddrIn[1:0]))
            || (is_load  && !aligned(MemReadIn,  AddrIn[1:0]));
    load_ok  = is_load && !illegal;
    store_ok = is_store && !illegal;
    hazard   = load_ok && (|match);
  end

  // Priority: clean load, hazard load (stall + drain), store (drain only if full), idle drain.
  always_comb begin
    Address   = '0;
    WriteData = '0;
    MemWrite  = MEM_NONE;
    MemRead   = MEM_NONE;
    Stall     = 1'b0;
    ReqError  = illegal;
    push      = 1'b0;
    drain     = 1'b0;

    if (load_ok && !hazard) begin
      MemRead = MemReadIn;
      Address = AddrIn;
    end else if (load_ok) begin
      Stall = 1'b1;
      drain = 1'b1;
    end else if (store_ok) begin
      push  = 1'b1;
      drain = Full;
    end else begin
      drain = !Empty;
    end

    if (drain) begin
      MemWrite  = head_entry.size;
      Address   = head_entry.addr;
      WriteData = head_entry.data;
    end

    if (Rst) begin
      Address   = '0;
      WriteData = '0;
      MemWrite  = MEM_NONE;
      MemRead   = MEM_NONE;
      Stall     = 1'b0;
      ReqError  = 1'b0;
      push      = 1'b0;
      drain     = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed scoreboard bench for store_buffer
module tb_store_buffer;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  MemWriteIn = '0;
  logic [1:0]  MemReadIn = '0;
  logic [31:0] AddrIn = '0;
  logic [31:0] WriteDataIn = '0;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  MemWrite;
  logic [1:0]  MemRead;
  logic        Stall;
  logic        ReqError;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  sb_entry_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .MemWriteIn  (MemWriteIn),
    .MemReadIn   (MemReadIn),
    .AddrIn      (AddrIn),
    .WriteDataIn (WriteDataIn),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .Stall       (Stall),
    .ReqError    (ReqError),
    .Count       (Count),
    .Full        (Full),
    .Empty       (Empty)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [1:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    MemWriteIn  = w;
    MemReadIn   = r;
    AddrIn      = a;
    WriteDataIn = d;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_q.push_back('{addr: a, data: d, size: s});
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  // Every memory write the DUT issues must match the oldest expected store.
  always @(negedge Clk) begin
    sb_entry_t e;
    if (!Rst) begin
      check("port_exclusive", 32'(MemWrite != MEM_NONE && MemRead != MEM_NONE), 32'd0);
      if (MemWrite != MEM_NONE) begin
        if (exp_q.size() == 0) begin
          check("write_unexpected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", Address, e.addr);
          check("wr_data", WriteData, e.data);
          check("wr_size", 32'(MemWrite), 32'(e.size));
        end
      end
    end
  end

  initial begin
    // reset state, including gating of a load presented during reset
    drive(MEM_NONE, MEM_WORD, 32'h40, 32'h0);
    step; step; #2;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_reqerr", 32'(ReqError), 32'd0);
    step;

    // byte store then idle drain
    Rst = 1'b0;
    drive(MEM_BYTE, MEM_NONE, 32'h5, 32'hAB);
    expect_wr(32'h5, 32'hAB, MEM_BYTE);
    #2 check("t1_push_nowrite", 32'(MemWrite), 32'd0);
    step;
    drive(MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    #2;
    check("t1_drain_size", 32'(MemWrite), 32'(MEM_BYTE));
    check("t1_drain_addr", Address, 32'h5);
    check("t1_drain_data", WriteData, 32'hAB);
    step; #2;
    check("t1_empty_after", 32'(Empty), 32'd1);
    step;

    // fill to DEPTH, then push-with-pop on full
    for (int i = 0; i < 4; i++) begin
      drive(MEM_WORD, MEM_NONE, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i));
      expect_wr(32'h10 + 32'(4 * i), 32'h1000 + 32'(i), MEM_WORD);
      #2 check("t2_fill_nowrite", 32'(MemWrite), 32'd0);
      step;
    end
    drive(MEM_WORD, MEM_NONE, 32'h20, 32'h1004);
    expect_wr(32'h20, 32'h1004, MEM_WORD);
    #2;
    check("t2_full", 32'(Full), 32'd1);
    check("t2_full_drain_addr", Address, 32'h10);
    check("t2_no_stall", 32'(Stall), 32'd0);
    step;
    drive(MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    #2 check("t2_count_held", 32'(Count), 32'd4);
    step; step; step; step; #2;
    check("t2_drained_empty", 32'(Empty), 32'd1);
    step;

    // load hitting a pending store stalls while it drains
    drive(MEM_WORD, MEM_NONE, 32'h14, 32'hDEAD0014);
    expect_wr(32'h14, 32'hDEAD0014, MEM_WORD);
    step;
    drive(MEM_NONE, MEM_WORD, 32'h14, 32'h0);
    #2;
    check("t3_stall", 32'(Stall), 32'd1);
    check("t3_stall_noread", 32'(MemRead), 32'd0);
    check("t3_stall_drain", 32'(MemWrite), 32'(MEM_WORD));
    step; #2;
    check("t3_retry_stall", 32'(Stall), 32'd0);
    check("t3_retry_read", 32'(MemRead), 32'(MEM_WORD));
    check("t3_retry_addr", Address, 32'h14);
    step;

    // non-overlapping load bypasses the buffer without draining
    drive(MEM_WORD, MEM_NONE, 32'h14, 32'h5555);
    expect_wr(32'h14, 32'h5555, MEM_WORD);
    step;
    drive(MEM_NONE, MEM_WORD, 32'h40, 32'h0);
    #2;
    check("t4_no_stall", 32'(Stall), 32'd0);
    check("t4_read", 32'(MemRead), 32'(MEM_WORD));
    check("t4_addr", Address, 32'h40);
    check("t4_no_drain", 32'(MemWrite), 32'd0);
    step;
    drive(MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    #2 check("t4_count_kept", 32'(Count), 32'd1);
    step; step;

    // illegal requests are dropped; an aligned half passes
    drive(MEM_NONE, MEM_WORD, 32'h6, 32'h0);
    #2;
    check("t5_word_misalign_err", 32'(ReqError), 32'd1);
    check("t5_word_misalign_rd", 32'(MemRead), 32'd0);
    step;
    drive(MEM_HALF, MEM_NONE, 32'h3, 32'h1234);
    #2;
    check("t5_half_misalign_err", 32'(ReqError), 32'd1);
    check("t5_half_misalign_wr", 32'(MemWrite), 32'd0);
    step;
    drive(MEM_WORD, MEM_WORD, 32'h0, 32'h0);
    #2;
    check("t5_both_err", 32'(ReqError), 32'd1);
    check("t5_both_rd", 32'(MemRead), 32'd0);
    check("t5_both_wr", 32'(MemWrite), 32'd0);
    step;
    drive(MEM_HALF, MEM_NONE, 32'h2, 32'hBEEF);
    expect_wr(32'h2, 32'hBEEF, MEM_HALF);
    #2;
    check("t5_count_unchanged", 32'(Count), 32'd0);
    check("t5_half_ok", 32'(ReqError), 32'd0);
    step;
    drive(MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    step; step;

    // reset in the middle of a drain discards everything
    for (int i = 0; i < 3; i++) begin
      drive(MEM_WORD, MEM_NONE, 32'h30 + 32'(4 * i), 32'h3000 + 32'(i));
      step;
    end
    drive(MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    #1 check("t6_count_before", 32'(Count), 32'd3);
    Rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(Count), 32'd0);
    check("t6_rst_memwrite", 32'(MemWrite), 32'd0);
    check("t6_rst_empty", 32'(Empty), 32'd1);
    step;
    Rst = 1'b0;
    step; step; step; step; #2;
    check("t6_after_count", 32'(Count), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
